mem_arbiter: RTL and testbench

//  Shares one physical memory port between the instruction-side requester (I, read-only)
//  and the data-side requester (D, read/write). D is the port behind the indirect-access

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one memory port between the
//               instruction-side (read-only) and data-side (read/write)
//               requesters; routes the memory response back to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic [15:0]           i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [15:0]           d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  m_read,
    output logic                  m_write,
    output logic [15:0]           m_address,
    output logic [LINE_WIDTH-1:0] m_wdata,
    input  logic [LINE_WIDTH-1:0] m_rdata,
    input  logic                  m_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t state_q, state_d;
    grant_t last_grant_q, last_grant_d;
    logic   d_pending;

    assign d_pending = d_read | d_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Strobes and responses are decoded from state_q only, so an asynchronous
    // reset drops them at once and an m_resp seen in IDLE is never forwarded.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_wdata      = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = m_rdata;
        d_rdata      = m_rdata;

        case (state_q)
            IDLE: begin
                if (i_read && d_pending) begin
                    if (last_grant_q == GRANT_I) begin
                        state_d      = D_BUSY;
                        last_grant_d = GRANT_D;
                    end else begin
                        state_d      = I_BUSY;
                        last_grant_d = GRANT_I;
                    end
                end else if (i_read) begin
                    state_d      = I_BUSY;
                    last_grant_d = GRANT_I;
                end else if (d_pending) begin
                    state_d      = D_BUSY;
                    last_grant_d = GRANT_D;
                end
            end

            I_BUSY: begin
                m_read    = 1'b1;
                m_address = i_address;
                i_resp    = m_resp;
                if (m_resp) begin
                    state_d = IDLE;
                end
            end

            D_BUSY: begin
                // Simultaneous read and write is resolved as a write.
                m_read    = d_read & ~d_write;
                m_write   = d_write;
                m_address = d_address;
                m_wdata   = d_wdata;
                d_resp    = m_resp;
                if (m_resp) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a latency-programmable
//               memory model; a monitor pops expected responses on i/d_resp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_read = 1'b0;
    logic [15:0]   i_address = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [15:0]   d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          m_read;
    logic          m_write;
    logic [15:0]   m_address;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_rdata = '0;
    logic          m_resp = 1'b0;

    mem_arbiter #(.LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_d;
        bit            chk;
        logic [LW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   mem_lat = 3;
    bit   inject = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic push(input bit is_d, input bit chk, input logic [LW-1:0] data);
        exp_t e;
        e.is_d = is_d; e.chk = chk; e.data = data;
        sb.push_back(e);
    endtask

    function automatic logic [LW-1:0] rd(input logic [15:0] a);
        return {8{a}};
    endfunction

    // Memory model: counts strobe cycles, then pulses m_resp for one cycle.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                cnt = 0; m_resp = 1'b0;
            end else if (inject) begin
                inject = 1'b0; m_resp = 1'b1;
            end else if (m_resp) begin
                m_resp = 1'b0;
            end else if (m_read || m_write) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    cnt     = 0;
                    m_resp  = 1'b1;
                    m_rdata = (m_address == 16'h1230) ? {16{8'hA5}} : rd(m_address);
                end
            end
        end
    end

    // Monitor
    initial begin
        bit prev_resp = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_resp) check("idle_gap", {126'd0, m_read, m_write}, '0);
            prev_resp = i_resp | d_resp;
            if (i_resp && d_resp) check("dual_resp", 1, 0);
            if (i_resp) begin
                if (sb.size() == 0) check("unexpected_i_resp", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("resp_owner_i", 0, {127'd0, e.is_d});
                    if (e.chk) check("i_rdata", i_rdata, e.data);
                end
            end
            if (d_resp) begin
                if (sb.size() == 0) check("unexpected_d_resp", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("resp_owner_d", 1, {127'd0, e.is_d});
                    if (e.chk) check("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    task automatic wait_resp(input bit is_d);
        bit seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (is_d ? d_resp : i_resp) seen = 1'b1;
        end
        if (!seen) check(is_d ? "d_timeout" : "i_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the response, request still held.
    task automatic i_req(input logic [15:0] a);
        i_read = 1'b1; i_address = a;
        wait_resp(1'b0);
    endtask

    task automatic d_req(input logic [15:0] a);
        d_read = 1'b1; d_write = 1'b0; d_address = a;
        wait_resp(1'b1);
    endtask

    task automatic i_idle();
        i_read = 1'b0;
    endtask

    task automatic d_idle();
        d_read = 1'b0; d_write = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_m_read", {127'd0, m_read}, 0);
        check("rst_m_write", {127'd0, m_write}, 0);
        check("rst_i_resp", {127'd0, i_resp}, 0);
        check("rst_d_resp", {127'd0, d_resp}, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;

        // 1: single I read, strobe one cycle after the request is seen
        mem_lat = 3;
        push(0, 1, {16{8'hA5}});
        i_read = 1'b1; i_address = 16'h1230;
        @(negedge clk);
        check("t1_no_strobe_yet", {127'd0, m_read}, 0);
        @(negedge clk);
        check("t1_m_read", {127'd0, m_read}, 1);
        check("t1_m_write", {127'd0, m_write}, 0);
        check("t1_m_address", {112'd0, m_address}, {112'd0, 16'h1230});
        wait_resp(1'b0);
        i_idle();

        // 2: simultaneous tie after an I grant goes to D; D re-request then loses to I
        mem_lat = 2;
        push(1, 1, rd(16'h3000));
        push(0, 1, rd(16'h2000));
        push(1, 1, rd(16'h3001));
        fork
            begin d_req(16'h3000); d_req(16'h3001); d_idle(); end
            begin i_req(16'h2000); i_idle(); end
        join

        // 3: D write, and read+write resolved as write
        push(1, 0, '0);
        d_write = 1'b1; d_address = 16'h4000; d_wdata = {8{16'h0123}};
        @(negedge clk); @(negedge clk);
        check("t3_m_write", {127'd0, m_write}, 1);
        check("t3_m_read", {127'd0, m_read}, 0);
        check("t3_m_wdata", m_wdata, {8{16'h0123}});
        check("t3_m_address", {112'd0, m_address}, {112'd0, 16'h4000});
        wait_resp(1'b1);
        push(1, 0, '0);
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h4010; d_wdata = {8{16'hBEEF}};
        @(negedge clk); @(negedge clk);
        check("t3b_m_write", {127'd0, m_write}, 1);
        check("t3b_m_read", {127'd0, m_read}, 0);
        check("t3b_m_wdata", m_wdata, {8{16'hBEEF}});
        wait_resp(1'b1);
        d_idle();

        // 4a: D streams while I waits; I wins the second arbitration
        push(1, 1, rd(16'hA000));
        push(0, 1, rd(16'hB000));
        push(1, 1, rd(16'hA001));
        push(1, 1, rd(16'hA002));
        fork
            begin d_req(16'hA000); d_req(16'hA001); d_req(16'hA002); d_idle(); end
            begin @(posedge clk); #1; i_req(16'hB000); i_idle(); end
        join

        // 4b: both streaming back-to-back strictly alternate
        for (int k = 0; k < 3; k++) begin
            push(0, 1, rd(16'hC000 + 16'(k)));
            push(1, 1, rd(16'hD000 + 16'(k)));
        end
        fork
            begin for (int k = 0; k < 3; k++) i_req(16'hC000 + 16'(k)); i_idle(); end
            begin for (int k = 0; k < 3; k++) d_req(16'hD000 + 16'(k)); d_idle(); end
        join

        // 5: reset during I_BUSY abandons the transaction
        mem_lat = 10;
        i_read = 1'b1; i_address = 16'h5555;
        @(negedge clk); @(negedge clk);
        check("t5_busy", {127'd0, m_read}, 1);
        #1 reset = 1'b1;
        #1;
        check("t5_rst_m_read", {127'd0, m_read}, 0);
        check("t5_rst_i_resp", {127'd0, i_resp}, 0);
        i_idle();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_idle_strobes", {126'd0, m_read, m_write}, 0);
        @(posedge clk); #1;
        mem_lat = 2;
        push(1, 1, rd(16'h0200));
        push(0, 1, rd(16'h0100));
        fork
            begin d_req(16'h0200); d_idle(); end
            begin i_req(16'h0100); i_idle(); end
        join

        // 6: m_resp in IDLE is ignored
        inject = 1'b1;
        @(negedge clk);
        check("t6_m_resp_seen", {127'd0, m_resp}, 1);
        check("t6_i_resp", {127'd0, i_resp}, 0);
        check("t6_d_resp", {127'd0, d_resp}, 0);
        @(negedge clk);
        check("t6_still_idle", {126'd0, m_read, m_write}, 0);
        @(posedge clk); #1;
        push(0, 1, rd(16'h0777));
        i_req(16'h0777);
        i_idle();

        repeat (5) @(posedge clk);
        check("sb_empty", LW'(sb.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
